// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   state_t            - loader FSM encoding (HDR, DATA, RUN, ERR)
//   DEPTH_LOG2_DEFAULT - default log2 of the memory depth in 32-bit words
//   NOP                - instruction returned outside RUN or out of range
//   oversize()         - true when a header word count exceeds the memory
// ----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 32
`endif

package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,  // receiving the 4-byte big-endian word count
    ST_DATA = 2'd1,  // receiving the image, 4 bytes per word
    ST_RUN  = 2'd2,  // serving instructions to the CPU
    ST_ERR  = 2'd3   // image too large; parked until rst
  } state_t;

  localparam int DEPTH_LOG2_DEFAULT = 10;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Word count n does not fit in 2**depth_log2 words. Done in 33 bits so a
  // count near 2**32 cannot wrap into range.
  function automatic logic oversize(input logic [31:0] n, input int depth_log2);
    return {1'b0, n} > (33'd1 << depth_log2);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// ----------------------------------------------------------------------------
// imem_ram
// Simple dual-port instruction memory: one write port, one synchronous read
// port, written so synthesis maps it onto block RAM. Contents are never
// cleared by reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address (sampled on the rising edge)
//   rdata  - registered read data, valid the cycle after raddr
// ----------------------------------------------------------------------------
module imem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Loads a program image from a byte stream into instruction memory, holds
// the CPU in reset while loading, then serves instruction fetches.
// Image format: 4-byte big-endian word count N, then N big-endian words.
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-high reset
//   rx_data         - loader byte
//   rx_valid        - rx_data valid
//   rx_ready        - loader can accept a byte (HDR and DATA only)
//   reload          - pulse in RUN restarts loading from the header
//   program_counter - CPU word address
//   instr           - registered instruction (NOP outside RUN / out of range)
//   cpu_rstn        - active-low CPU reset, high only in RUN
//   load_done       - high in RUN
//   load_err        - high in ERR (oversize image)
// ----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 32
`endif

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int WIDTH      = `WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             reload,
  input  logic [WIDTH-1:0] program_counter,
  output logic [WIDTH-1:0] instr,
  output logic             cpu_rstn,
  output logic             load_done,
  output logic             load_err
);

  state_t                state_reg, state_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [DEPTH_LOG2-1:0] waddr_reg, waddr_next;
  logic [DEPTH_LOG2-1:0] last_waddr_reg, last_waddr_next;
  // Only the three most recent bytes are kept; the fourth byte is combined
  // directly from rx_data when a word completes.
  logic [23:0]           asm_reg, asm_next;
  logic                  cpu_rstn_reg, cpu_rstn_next;
  logic                  load_done_reg, load_done_next;
  logic                  load_err_reg, load_err_next;
  // Read qualifier travels alongside the RAM's registered read data so that
  // instr is NOP for reads issued outside RUN or beyond the memory.
  logic                  rd_ok_reg, rd_ok_next;

  logic                  xfer;
  logic                  word_done;
  logic [31:0]           word;
  logic                  pc_oob;
  logic                  mem_we;
  logic [WIDTH-1:0]      ram_rdata;

  assign rx_ready  = (state_reg == ST_HDR) || (state_reg == ST_DATA);
  assign xfer      = rx_valid && rx_ready;
  assign word_done = xfer && (byte_cnt_reg == 2'd3);
  assign word      = {asm_reg, rx_data};
  assign pc_oob    = |program_counter[WIDTH-1:DEPTH_LOG2];

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    waddr_next      = waddr_reg;
    last_waddr_next = last_waddr_reg;
    asm_next        = asm_reg;
    mem_we          = 1'b0;

    if (xfer) begin
      byte_cnt_next = 2'(byte_cnt_reg + 2'd1);
      asm_next      = word[23:0];
    end

    case (state_reg)
      ST_HDR: begin
        if (word_done) begin
          if (word == 32'd0) begin
            state_next = ST_RUN;
          end else if (oversize(word, DEPTH_LOG2)) begin
            state_next = ST_ERR;
          end else begin
            state_next      = ST_DATA;
            waddr_next      = '0;
            // N <= depth here, so N-1 always fits the address width.
            last_waddr_next = DEPTH_LOG2'(word - 32'd1);
          end
        end
      end
      ST_DATA: begin
        if (word_done) begin
          mem_we     = 1'b1;
          waddr_next = DEPTH_LOG2'(waddr_reg + 1'b1);
          if (waddr_reg == last_waddr_reg) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_next    = ST_HDR;
          byte_cnt_next = 2'd0;
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_HDR;
      end
    endcase

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    cpu_rstn_next  = (state_next == ST_RUN);
    load_done_next = (state_next == ST_RUN);
    load_err_next  = (state_next == ST_ERR);
    rd_ok_next     = (state_reg == ST_RUN) && !pc_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_HDR;
      byte_cnt_reg   <= 2'd0;
      waddr_reg      <= '0;
      last_waddr_reg <= '0;
      asm_reg        <= '0;
      cpu_rstn_reg   <= 1'b0;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
      rd_ok_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      waddr_reg      <= waddr_next;
      last_waddr_reg <= last_waddr_next;
      asm_reg        <= asm_next;
      cpu_rstn_reg   <= cpu_rstn_next;
      load_done_reg  <= load_done_next;
      load_err_reg   <= load_err_next;
      rd_ok_reg      <= rd_ok_next;
    end
  end

  // The write lands on the same edge that moves the FSM into RUN, so the
  // first RUN read (one edge later) already sees the last word. A write
  // coinciding with rst is suppressed so reset wins over the transfer.
  imem_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we && !rst),
    .waddr (waddr_reg),
    .wdata (WIDTH'(word)),
    .raddr (program_counter[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  assign instr     = rd_ok_reg ? ram_rdata : WIDTH'(NOP);
  assign cpu_rstn  = cpu_rstn_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

endmodule
